// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Drives a byte-wide program memory to build whole 32-bit instructions.
//   It holds the program counter, issues four byte reads per instruction and
//   packs the bytes big-endian, so the first byte read lands in bits 31:24.
//   The finished instruction goes to decode over a valid/ready handshake.
//   The block also handles branch redirects and out-of-range fetch faults.
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   MEM_BYTES  program memory size in bytes; a fetch is legal only when
//              pc+3 <= MEM_BYTES-1
//
// Ports:
//   clk             in   1   clock, rising edge
//   reset           in   1   asynchronous, active-high reset
//   run             in   1   fetching permitted (sampled when a fetch starts)
//   mem_en          out  1   byte read strobe
//   mem_addr        out  32  byte read address (0 when mem_en=0)
//   mem_rdata       in   8   read byte, valid one cycle after mem_en
//   instr_valid     out  1   instr_code/instr_pc hold a complete instruction
//   instr_ready     in   1   decode accepts the instruction
//   instr_code      out  32  assembled instruction {b0,b1,b2,b3}
//   instr_pc        out  32  byte address of b0
//   redirect_valid  in   1   restart fetch at redirect_pc
//   redirect_pc     in   32  new PC; any byte alignment is allowed
//   fetch_fault     out  1   PC out of range; fetching halted
//
// States:
//   state | meaning
//   IDLE  | waiting for run; range-checks pc before each fetch
//   FETCH | cnt 0..3 issue reads at pc+cnt; cnt 1..4 capture b0..b3
//   HOLD  | instruction presented to decode until it is accepted
//   FAULT | pc out of range; only a redirect or reset leaves this state
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_BYTES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_code,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] code_q, code_d;
  logic [31:0] ipc_q, ipc_d;

  // The range check uses a 33-bit sum so that a pc near 2^32 whose last
  // byte would wrap around still counts as out of range.
  function automatic logic pc_in_range(input logic [31:0] p);
    return ({1'b0, p} + 33'd3) < 33'(MEM_BYTES);
  endfunction

  // Decision made when the fetcher is (or behaves as if it is) in IDLE.
  // The same decision is used after a handshake and after a redirect, so a
  // running fetcher never spends a bubble cycle in IDLE.
  function automatic state_t idle_decide(input logic run_i, input logic [31:0] p);
    state_t s;
    if (!run_i)
      s = IDLE;
    else if (pc_in_range(p))
      s = FETCH;
    else
      s = FAULT;
    return s;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
      code_q  <= 32'd0;
      ipc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    ipc_d   = ipc_q;

    if (redirect_valid) begin
      // Restarting cnt at 0 discards any partial bytes. The byte already in
      // flight arrives during the new cnt=0 cycle, and no byte is captured
      // in that cycle.
      pc_d    = redirect_pc;
      cnt_d   = 3'd0;
      state_d = idle_decide(run, redirect_pc);
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = 3'd0;
          state_d = idle_decide(run, pc_q);
        end

        FETCH: begin
          if (cnt_q != 3'd0)
            code_d = {code_q[23:0], mem_rdata};
          if (cnt_q == 3'd4) begin
            cnt_d   = 3'd0;
            ipc_d   = pc_q;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end

        HOLD: begin
          if (instr_ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = idle_decide(run, pc_q + 32'd4);
          end
        end

        FAULT: begin
          state_d = FAULT;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs decode the state register directly, so an asynchronous reset
  // clears them immediately, without waiting for a clock edge.
  always_comb begin
    mem_en      = (state_q == FETCH) && (cnt_q < 3'd4);
    mem_addr    = mem_en ? (pc_q + {29'd0, cnt_q}) : 32'd0;
    instr_valid = (state_q == HOLD);
    fetch_fault = (state_q == FAULT);
    instr_code  = code_q;
    instr_pc    = ipc_q;
  end

endmodule
